lrf_axis_pixel_unpacker: RTL and testbench

//   LRF input stage directly downstream of the 128-bit DDR AXI-Stream source.

---
 rtl/lrf_pkg.sv | 25 ++
 rtl/lrf_axis_pixel_unpacker_if.sv | 16 +
 rtl/lrf_raster_counter.sv | 61 ++++++
 rtl/lrf_axis_pixel_unpacker.sv | 117 +++++++++++
 tb/tb_lrf_axis_pixel_unpacker.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lrf_pkg.sv
// Shared LRF constants: default geometry, frame phase encoding, tuser bit layout
// and a counter-width helper.
package lrf_pkg;

    localparam int unsigned LRF_WORD_WIDTH   = 128;
    localparam int unsigned LRF_PIXEL_WIDTH  = 8;
    localparam int unsigned LRF_IMAGE_WIDTH  = 512;
    localparam int unsigned LRF_IMAGE_HEIGHT = 512;
    localparam int unsigned LRF_PPW          = LRF_WORD_WIDTH / LRF_PIXEL_WIDTH;

    typedef enum logic {
        LRF_PHASE_OLD = 1'b0,
        LRF_PHASE_NEW = 1'b1
    } lrf_phase_e;

    localparam int unsigned LRF_TUSER_SOF   = 0;
    localparam int unsigned LRF_TUSER_PHASE = 1;
    localparam int unsigned LRF_TUSER_W     = 2;

    // A range of one value still needs a 1-bit register.
    function automatic int unsigned lrf_cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lrf_axis_pixel_unpacker_if.sv
// AXI-Stream bundle shared by the packed-word input and the pixel output.
interface lrf_axis_pixel_unpacker_if
    import lrf_pkg::*;
#(
    parameter int unsigned DATA_W = LRF_PIXEL_WIDTH,
    parameter int unsigned USER_W = LRF_TUSER_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/lrf_raster_counter.sv
// Raster position tracker: col/row counters plus frame phase, advanced one pixel per enable.
module lrf_raster_counter
    import lrf_pkg::*;
#(
    parameter int unsigned COLS = LRF_IMAGE_WIDTH,
    parameter int unsigned ROWS = LRF_IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic       first_o,
    output logic       col_last_o,
    output logic       frame_last_o,
    output lrf_phase_e phase_o
);
    localparam int unsigned CW = lrf_cw(COLS);
    localparam int unsigned RW = lrf_cw(ROWS);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    lrf_phase_e    phase_q, phase_d;
    logic          row_last;

    assign col_last_o   = (col_q == CW'(COLS - 1));
    assign row_last     = (row_q == RW'(ROWS - 1));
    assign frame_last_o = col_last_o & row_last;
    assign first_o      = (col_q == '0) & (row_q == '0);
    assign phase_o      = phase_q;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        if (en_i) begin
            if (col_last_o) begin
                col_d = '0;
                if (row_last) begin
                    row_d   = '0;
                    phase_d = (phase_q == LRF_PHASE_OLD) ? LRF_PHASE_NEW : LRF_PHASE_OLD;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            phase_q <= LRF_PHASE_OLD;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lrf_axis_pixel_unpacker.sv
// Unpacks wide DDR words into one tagged pixel per beat, raster order, full rate.
module lrf_axis_pixel_unpacker
    import lrf_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = LRF_WORD_WIDTH,
    parameter int unsigned PIXEL_WIDTH  = LRF_PIXEL_WIDTH,
    parameter int unsigned IMAGE_WIDTH  = LRF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = LRF_IMAGE_HEIGHT
) (
    input  logic                        s_axis_aclk,
    input  logic                        s_axis_areset,
    lrf_axis_pixel_unpacker_if.slave    s_axis,
    lrf_axis_pixel_unpacker_if.master   m_axis,
    output logic                        frame_done,
    output logic                        err_tlast
);
    localparam int unsigned PPW = WORD_WIDTH / PIXEL_WIDTH;
    localparam int unsigned SW  = lrf_cw(PPW);
    localparam int unsigned WPF = (IMAGE_WIDTH * IMAGE_HEIGHT) / PPW;
    localparam int unsigned WW  = lrf_cw(WPF);

    logic [PPW-1:0][PIXEL_WIDTH-1:0] word_q, word_d;
    logic                            full_q, full_d;
    logic [SW-1:0]                   sub_q, sub_d;
    logic [WW-1:0]                   wcnt_q, wcnt_d;
    lrf_phase_e                      in_phase_q, in_phase_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;

    logic       last_lane, s_hs, m_hs, w_wrap, w_final;
    logic       px_first, px_col_last, px_frame_last;
    lrf_phase_e px_phase;

    assign last_lane     = (sub_q == SW'(PPW - 1));
    assign s_axis.tready = ~full_q | (last_lane & m_axis.tready);
    assign s_hs          = s_axis.tvalid & s_axis.tready;
    assign m_hs          = full_q & m_axis.tready;

    // Output fields are forced to zero while the holding register is empty.
    assign m_axis.tvalid                 = full_q;
    assign m_axis.tdata                  = full_q ? word_q[sub_q] : '0;
    assign m_axis.tlast                  = full_q & px_col_last;
    assign m_axis.tuser[LRF_TUSER_SOF]   = full_q & px_first;
    assign m_axis.tuser[LRF_TUSER_PHASE] = full_q & (px_phase == LRF_PHASE_NEW);
    assign frame_done                    = done_q;
    assign err_tlast                     = err_q;

    // Input-side word position, only used to judge whether tlast is legitimate.
    assign w_wrap  = (wcnt_q == WW'(WPF - 1));
    assign w_final = w_wrap & (in_phase_q == LRF_PHASE_NEW);

    always_comb begin
        word_d     = word_q;
        full_d     = full_q;
        sub_d      = sub_q;
        wcnt_d     = wcnt_q;
        in_phase_d = in_phase_q;
        err_d      = err_q;
        done_d     = m_hs & px_frame_last;
        if (s_hs) begin
            // A load coinciding with the last-lane handshake keeps full set.
            word_d = s_axis.tdata;
            full_d = 1'b1;
            sub_d  = '0;
            if (w_wrap) begin
                wcnt_d     = '0;
                in_phase_d = (in_phase_q == LRF_PHASE_OLD) ? LRF_PHASE_NEW : LRF_PHASE_OLD;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
            if (s_axis.tlast & ~w_final) begin
                err_d = 1'b1;
            end
        end else if (m_hs) begin
            if (last_lane) begin
                full_d = 1'b0;
                sub_d  = '0;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            word_q     <= '0;
            full_q     <= 1'b0;
            sub_q      <= '0;
            wcnt_q     <= '0;
            in_phase_q <= LRF_PHASE_OLD;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            word_q     <= word_d;
            full_q     <= full_d;
            sub_q      <= sub_d;
            wcnt_q     <= wcnt_d;
            in_phase_q <= in_phase_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    lrf_raster_counter #(
        .COLS (IMAGE_WIDTH),
        .ROWS (IMAGE_HEIGHT)
    ) u_px_cnt (
        .clk          (s_axis_aclk),
        .rst          (s_axis_areset),
        .en_i         (m_hs),
        .first_o      (px_first),
        .col_last_o   (px_col_last),
        .frame_last_o (px_frame_last),
        .phase_o      (px_phase)
    );

endmodule

// File: tb/tb_lrf_axis_pixel_unpacker.sv
// Bench for lrf_axis_pixel_unpacker in a 32x2 configuration with a queue-based pixel model.
module tb_lrf_axis_pixel_unpacker;
    localparam int W   = 32;
    localparam int H   = 2;
    localparam int PPW = 16;
    localparam int PPF = W * H;
    localparam int WPF = PPF / PPW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lrf_axis_pixel_unpacker_if #(.DATA_W(128), .USER_W(1)) s_if ();
    lrf_axis_pixel_unpacker_if #(.DATA_W(8),   .USER_W(2)) m_if ();
    logic frame_done, err_tlast;

    lrf_axis_pixel_unpacker #(
        .WORD_WIDTH   (128),
        .PIXEL_WIDTH  (8),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_done    (frame_done),
        .err_tlast     (err_tlast)
    );

    int total = 0;
    int bad   = 0;

    logic [127:0] wq[$];
    int           pix, src_k, tlast_k, word_limit, cyc;
    logic [127:0] src_cur;
    bit           rand_data, fd_exp, err_exp, stall_prev;
    logic [7:0]   prev_data;
    logic         prev_last;
    logic [1:0]   prev_user;

    logic [7:0] data_log[256];
    logic       last_log[256];
    logic [1:0] user_log[256];
    int         cyc_log[256];

    typedef struct {
        int         p;
        logic [7:0] data;
        logic       last;
        logic [1:0] user;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d, pixel %0d)", name, act, exp, cyc, pix);
        end
    endtask

    function automatic logic [127:0] gen_word(input int k);
        logic [127:0] w;
        for (int j = 0; j < PPW; j++) begin
            if (rand_data) w[j*8 +: 8] = 8'($urandom_range(0, 255));
            else           w[j*8 +: 8] = 8'(16 * k + j);
        end
        return w;
    endfunction

    task automatic model_reset();
        wq.delete();
        pix        = 0;
        src_k      = 0;
        src_cur    = gen_word(0);
        fd_exp     = 1'b0;
        err_exp    = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_m_tuser", m_if.tuser, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_tlast", err_tlast, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: drive at the falling edge, check and update the model 1 ns later.
    task automatic step(input bit sv, input bit mr);
        bit           go, fd_nxt, err_nxt;
        logic [127:0] w;
        logic [1:0]   eu;
        int           lane;
        @(negedge clk);
        go          = sv && (src_k < word_limit);
        s_if.tvalid = go;
        s_if.tdata  = src_cur;
        s_if.tlast  = (src_k == tlast_k);
        m_if.tready = mr;
        #1;
        chk("frame_done", frame_done, fd_exp);
        chk("err_tlast", err_tlast, err_exp);
        chk("m_tvalid", m_if.tvalid, wq.size() != 0);
        chk("s_tready", s_if.tready, (wq.size() == 0) || ((pix % PPW == PPW - 1) && mr));
        if (stall_prev) begin
            chk("stall_tvalid", m_if.tvalid, 1);
            chk("stall_tdata", m_if.tdata, prev_data);
            chk("stall_tlast", m_if.tlast, prev_last);
            chk("stall_tuser", m_if.tuser, prev_user);
        end
        fd_nxt  = 1'b0;
        err_nxt = err_exp;
        if (m_if.tvalid && mr && wq.size() != 0) begin
            w     = wq[0];
            lane  = pix % PPW;
            eu[1] = 1'((pix / PPF) % 2);
            eu[0] = (pix % PPF == 0);
            chk("pix_data", m_if.tdata, w[lane*8 +: 8]);
            chk("pix_tlast", m_if.tlast, (pix % W) == W - 1);
            chk("pix_tuser", m_if.tuser, eu);
            if (pix < 256) begin
                data_log[pix] = m_if.tdata;
                last_log[pix] = m_if.tlast;
                user_log[pix] = m_if.tuser;
                cyc_log[pix]  = cyc;
            end
            if (lane == PPW - 1) void'(wq.pop_front());
            if (pix % PPF == PPF - 1) fd_nxt = 1'b1;
            pix++;
        end
        if (go && s_if.tready) begin
            if (s_if.tlast && !((src_k % WPF == WPF - 1) && ((src_k / WPF) % 2 == 1)))
                err_nxt = 1'b1;
            wq.push_back(src_cur);
            src_k++;
            src_cur = gen_word(src_k);
        end
        stall_prev = m_if.tvalid && !mr;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;
        prev_user  = m_if.tuser;
        fd_exp     = fd_nxt;
        err_exp    = err_nxt;
        cyc++;
    endtask

    task automatic run_until(input int target, input int max_cyc, input bit rnd);
        int n = 0;
        while (pix < target && n < max_cyc) begin
            if (rnd) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else     step(1'b1, 1'b1);
            n++;
        end
        chk("reach_pixel_count", pix, target);
    endtask

    initial begin
        vec_t tbl[10];
        int   sr;
        tbl[0] = '{0,   8'd0,   1'b0, 2'b01};
        tbl[1] = '{15,  8'd15,  1'b0, 2'b00};
        tbl[2] = '{16,  8'd16,  1'b0, 2'b00};
        tbl[3] = '{31,  8'd31,  1'b1, 2'b00};
        tbl[4] = '{32,  8'd32,  1'b0, 2'b00};
        tbl[5] = '{63,  8'd63,  1'b1, 2'b00};
        tbl[6] = '{64,  8'd64,  1'b0, 2'b11};
        tbl[7] = '{127, 8'd127, 1'b1, 2'b10};
        tbl[8] = '{128, 8'd128, 1'b0, 2'b01};
        tbl[9] = '{200, 8'd200, 1'b0, 2'b10};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;
        rand_data   = 1'b0;
        tlast_k     = -1;
        word_limit  = 1 << 30;
        cyc         = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Full rate ramp over several frames, then table comparison
        word_limit = 14;
        run_until(224, 400, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl_data_p%0d", tbl[i].p), data_log[tbl[i].p], tbl[i].data);
            chk($sformatf("tbl_last_p%0d", tbl[i].p), last_log[tbl[i].p], tbl[i].last);
            chk($sformatf("tbl_user_p%0d", tbl[i].p), user_log[tbl[i].p], tbl[i].user);
        end
        chk("no_gap_span", cyc_log[223] - cyc_log[0], 223);
        repeat (3) step(1'b0, 1'b1);

        // Random handshakes with random data, four frames
        rand_data = 1'b1;
        do_reset();
        word_limit = 16;
        run_until(256, 3000, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        chk("scoreboard_count", pix, 256);
        chk("scoreboard_empty", wq.size(), 0);

        // Downstream stall at lane 5 for 40 cycles
        rand_data = 1'b0;
        do_reset();
        word_limit = 1 << 30;
        run_until(21, 100, 1'b0);
        sr = 0;
        repeat (40) begin
            step(1'b1, 1'b0);
            if (s_if.tready) sr++;
        end
        chk("stall_s_tready_highs", sr, 0);
        chk("stall_held_pixel", m_if.tdata, 21);
        chk("stall_no_advance", pix, 21);
        run_until(64, 200, 1'b0);

        // Reset at row 1, col 10
        run_until(PPF + 42, 200, 1'b0);
        do_reset();
        run_until(1, 20, 1'b0);
        chk("post_rst_tuser", user_log[0], 2'b01);
        chk("post_rst_data", data_log[0], 8'd0);
        chk("post_rst_tlast", last_log[0], 1'b0);

        // tlast on the final word of a phase-1 frame is legal
        do_reset();
        tlast_k    = 2 * WPF - 1;
        word_limit = 2 * WPF;
        run_until(2 * PPF, 400, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        chk("legal_tlast_err", err_tlast, 1'b0);

        // tlast on word 2 of a phase-0 frame is flagged and sticky
        do_reset();
        tlast_k    = 2;
        word_limit = WPF;
        run_until(PPF, 200, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        chk("early_tlast_err", err_tlast, 1'b1);
        chk("early_tlast_frame_len", pix, PPF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
